// File: rtl/tt_stbuf_pkg.sv
// Shared types and constants for the coalescing store buffer.
// Holds the entry layout plus line-offset and count widths.
package tt_stbuf_pkg;

    localparam int SB_DATA_W = 128;
    localparam int SB_ADDR_W = 48;
    localparam int SB_NB     = SB_DATA_W / 8;
    localparam int SB_DEPTH  = 8;
    localparam int LINE_OFF  = $clog2(SB_NB);
    localparam int CNT_W     = $clog2(SB_DEPTH) + 1;

    typedef struct packed {
        logic                 vld;
        logic                 ordered;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_NB-1:0]     byten;
        logic [SB_DATA_W-1:0] data;
    } stbuf_entry_t;

endpackage

// File: rtl/tt_stbuf_fwd_match.sv
// Per-byte youngest-writer select across the store buffer entries.
// Ports: entries/rd_ptr/count (age order), ld_addr/ld_byten (probe),
//        fwd_data (bytes in overlap), fwd_byten (all covered bytes),
//        overlap (covered bytes the load needs).
module tt_stbuf_fwd_match
    import tt_stbuf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  stbuf_entry_t               entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [SB_ADDR_W-1:0]       ld_addr,
    input  logic [SB_NB-1:0]           ld_byten,
    output logic [SB_DATA_W-1:0]       fwd_data,
    output logic [SB_NB-1:0]           fwd_byten,
    output logic [SB_NB-1:0]           overlap
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     idx;
    logic [SB_DATA_W-1:0] raw_data;
    logic                 unused_low;

    assign unused_low = ^ld_addr[LINE_OFF-1:0];

    // Walk oldest to youngest so a younger writer overrides each byte.
    always_comb begin
        idx       = '0;
        raw_data  = '0;
        fwd_byten = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (k < int'(count) && entries[idx].vld &&
                entries[idx].addr[SB_ADDR_W-1:LINE_OFF] ==
                ld_addr[SB_ADDR_W-1:LINE_OFF]) begin
                for (int b = 0; b < SB_NB; b++) begin
                    if (entries[idx].byten[b]) begin
                        fwd_byten[b]       = 1'b1;
                        raw_data[8*b +: 8] = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign overlap = fwd_byten & ld_byten;

    always_comb begin
        fwd_data = '0;
        for (int b = 0; b < SB_NB; b++) begin
            if (overlap[b]) fwd_data[8*b +: 8] = raw_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/tt_store_buffer_fwd.sv
// Circular store buffer with youngest-entry coalescing, lone-entry hold
// timer and per-byte store-to-load forwarding.
// Ports: i_wr_* store in (valid/ready), o_drain_* head out (valid/ready),
//        i_ld_* probe -> o_ld_fwd_*/o_ld_conflict, control i_merge_disable,
//        i_flush, i_timer_max, status o_empty/o_full/o_count.
module tt_store_buffer_fwd
    import tt_stbuf_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_W,
    parameter int ADDR_WIDTH = SB_ADDR_W,
    parameter int DEPTH      = SB_DEPTH,
    parameter int MERGE_EN   = 1,
    parameter int FWD_EN     = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wr_byten,
    input  logic                      i_wr_ordered,
    output logic                      o_drain_valid,
    input  logic                      i_drain_ready,
    output logic [ADDR_WIDTH-1:0]     o_drain_addr,
    output logic [DATA_WIDTH-1:0]     o_drain_data,
    output logic [DATA_WIDTH/8-1:0]   o_drain_byten,
    output logic                      o_drain_ordered,
    input  logic                      i_ld_valid,
    input  logic [ADDR_WIDTH-1:0]     i_ld_addr,
    input  logic [DATA_WIDTH/8-1:0]   i_ld_byten,
    output logic [DATA_WIDTH-1:0]     o_ld_fwd_data,
    output logic [DATA_WIDTH/8-1:0]   o_ld_fwd_byten,
    output logic                      o_ld_conflict,
    input  logic                      i_merge_disable,
    input  logic                      i_flush,
    input  logic [4:0]                i_timer_max,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LO    = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    stbuf_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] yng;
    logic [CW-1:0]    count;
    logic [4:0]       timer;

    logic             full;
    logic             drain_valid;
    logic             pop;
    logic             line_eq;
    logic             merge_hit;
    logic             accept;
    logic             alloc;
    logic             any_ord;
    logic [DATA_WIDTH-1:0] wr_masked;
    logic [DATA_WIDTH-1:0] m_data;
    logic [NB-1:0]         m_byten;
    logic [DATA_WIDTH-1:0] match_data;
    logic [NB-1:0]         match_byten;
    logic [NB-1:0]         match_overlap;

    assign yng  = wr_ptr - PTR_W'(1);
    assign full = (count == CW'(DEPTH));

    // A lone entry waits for the timer so later stores can coalesce.
    assign drain_valid = mem[rd_ptr].vld &
                         ((count > CW'(1)) | mem[rd_ptr].ordered |
                          (timer == i_timer_max) | i_flush |
                          i_merge_disable | (MERGE_EN == 0));
    assign pop = drain_valid & i_drain_ready;

    assign line_eq = mem[yng].addr[ADDR_WIDTH-1:LO] ==
                     i_wr_addr[ADDR_WIDTH-1:LO];

    // Never merge into a head that is leaving this cycle.
    assign merge_hit = (MERGE_EN != 0) & i_wr_valid & ~i_merge_disable &
                       ~i_wr_ordered & mem[yng].vld & ~mem[yng].ordered &
                       line_eq & ~((yng == rd_ptr) & pop);

    assign o_wr_ready = merge_hit | ~full;
    assign accept     = i_wr_valid & o_wr_ready;
    assign alloc      = accept & ~merge_hit;

    always_comb begin
        wr_masked = '0;
        m_data    = mem[yng].data;
        m_byten   = mem[yng].byten | i_wr_byten;
        for (int b = 0; b < NB; b++) begin
            if (i_wr_byten[b]) begin
                wr_masked[8*b +: 8] = i_wr_data[8*b +: 8];
                m_data[8*b +: 8]    = i_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i].vld <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
        end else begin
            if (pop) begin
                mem[rd_ptr].vld <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (alloc) begin
                mem[wr_ptr].vld     <= 1'b1;
                mem[wr_ptr].ordered <= i_wr_ordered;
                mem[wr_ptr].addr    <= {i_wr_addr[ADDR_WIDTH-1:LO], {LO{1'b0}}};
                mem[wr_ptr].byten   <= i_wr_byten;
                mem[wr_ptr].data    <= wr_masked;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end else if (accept) begin
                mem[yng].byten <= m_byten;
                mem[yng].data  <= m_data;
            end
            count <= count + CW'(alloc) - CW'(pop);
            if (accept)
                timer <= '0;
            else if (count == CW'(1))
                timer <= (timer < i_timer_max) ? timer + 5'd1 : i_timer_max;
            else
                timer <= '0;
        end
    end

    assign o_drain_valid   = drain_valid;
    assign o_drain_addr    = mem[rd_ptr].addr;
    assign o_drain_data    = mem[rd_ptr].data;
    assign o_drain_byten   = mem[rd_ptr].byten;
    assign o_drain_ordered = mem[rd_ptr].ordered;
    assign o_empty         = (count == '0);
    assign o_full          = full;
    assign o_count         = count;

    tt_stbuf_fwd_match #(.DEPTH(DEPTH)) u_match (
        .entries   (mem),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .ld_addr   (i_ld_addr),
        .ld_byten  (i_ld_byten),
        .fwd_data  (match_data),
        .fwd_byten (match_byten),
        .overlap   (match_overlap)
    );

    always_comb begin
        any_ord = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            any_ord = any_ord | (mem[i].vld & mem[i].ordered);
    end

    // Conflict stays live even with forwarding removed.
    assign o_ld_fwd_byten = (FWD_EN != 0 && i_ld_valid) ?
                            (match_byten & i_ld_byten) : '0;
    assign o_ld_fwd_data  = (FWD_EN != 0 && i_ld_valid) ? match_data : '0;
    assign o_ld_conflict  = i_ld_valid &
                            (any_ord | ((match_overlap != '0) &
                                        (match_overlap != i_ld_byten)));

endmodule

// File: tb/tb_tt_store_buffer_fwd.sv
// Directed and randomized bench for tt_store_buffer_fwd, using a
// queue-based reference of the buffer contents and hold timer.
module tb_tt_store_buffer_fwd;

    localparam int DW = 128;
    localparam int AW = 48;
    localparam int NB = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic wr_valid, wr_ready, wr_ord;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_byten;
    logic dv_o, drain_ready, d_ord;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data;
    logic [NB-1:0] d_byten;
    logic ld_valid, ld_conf;
    logic [AW-1:0] ld_addr;
    logic [NB-1:0] ld_byten, ld_fbyten;
    logic [DW-1:0] ld_fdata;
    logic mdis, flush, empty, full;
    logic [4:0] tmax;
    logic [3:0] count;

    always #5 clk = ~clk;

    tt_store_buffer_fwd dut (
        .i_clk(clk), .i_reset(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_byten(wr_byten), .i_wr_ordered(wr_ord),
        .o_drain_valid(dv_o), .i_drain_ready(drain_ready),
        .o_drain_addr(d_addr), .o_drain_data(d_data),
        .o_drain_byten(d_byten), .o_drain_ordered(d_ord),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr),
        .i_ld_byten(ld_byten), .o_ld_fwd_data(ld_fdata),
        .o_ld_fwd_byten(ld_fbyten), .o_ld_conflict(ld_conf),
        .i_merge_disable(mdis), .i_flush(flush),
        .i_timer_max(tmax), .o_empty(empty), .o_full(full),
        .o_count(count)
    );

    typedef struct {
        logic [AW-1:0] line;
        logic [DW-1:0] data;
        logic [NB-1:0] byten;
        bit            ord;
    } ment_t;

    ment_t q[$];
    int tmr = 0;
    int errors = 0;
    int checks = 0;
    bit seen_dv;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_data;
    logic [NB-1:0] seen_byten;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lineof(input logic [AW-1:0] a);
        return {a[AW-1:4], 4'h0};
    endfunction

    function automatic logic [DW-1:0] bmask(input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // One clock: check outputs mid-cycle against the queue model, then
    // apply the cycle's handshakes to the model at the clock edge.
    task automatic step();
        bit dv, mh, rdy, acc, anyo, conf, hit;
        int n;
        logic [NB-1:0] cov, ov;
        logic [DW-1:0] fd;
        @(negedge clk);
        seen_dv    = dv_o;
        seen_addr  = d_addr;
        seen_data  = d_data;
        seen_byten = d_byten;
        if (rst) begin
            @(posedge clk);
            q.delete();
            tmr = 0;
            #1;
            return;
        end
        n  = q.size();
        dv = n > 0 && (n > 1 || q[0].ord || tmr == int'(tmax) ||
                       flush || mdis);
        mh = wr_valid && !mdis && !wr_ord && n > 0 && !q[n-1].ord &&
             q[n-1].line == lineof(wr_addr) &&
             !(n == 1 && dv && drain_ready);
        rdy = mh || n < DEPTH;
        acc = wr_valid && rdy;
        anyo = 0;
        for (int i = 0; i < n; i++) anyo |= q[i].ord;
        cov = '0;
        fd  = '0;
        if (ld_valid) begin
            for (int b = 0; b < NB; b++) begin
                hit = 0;
                for (int i = n - 1; i >= 0; i--) begin
                    if (!hit && q[i].line == lineof(ld_addr) && q[i].byten[b]) begin
                        hit = 1;
                        cov[b] = 1'b1;
                        fd[8*b +: 8] = q[i].data[8*b +: 8];
                    end
                end
            end
        end
        ov = cov & ld_byten;
        fd = fd & bmask(ov);
        conf = ld_valid && (anyo || (ov != 0 && ov != ld_byten));
        chk("drain_valid", dv_o, dv);
        if (dv) begin
            chk("drain_addr", d_addr, q[0].line);
            chk("drain_data", d_data, q[0].data);
            chk("drain_byten", d_byten, q[0].byten);
            chk("drain_ordered", d_ord, q[0].ord);
        end
        chk("wr_ready", wr_ready, rdy);
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("full", full, n == DEPTH);
        chk("ld_fwd_byten", ld_fbyten, ov);
        chk("ld_fwd_data", ld_fdata, fd);
        chk("ld_conflict", ld_conf, conf);
        @(posedge clk);
        if (dv && drain_ready) void'(q.pop_front());
        if (acc) begin
            if (mh) begin
                q[$].data  = (q[$].data & ~bmask(wr_byten)) |
                             (wr_data & bmask(wr_byten));
                q[$].byten = q[$].byten | wr_byten;
            end else begin
                q.push_back('{lineof(wr_addr), wr_data & bmask(wr_byten),
                              wr_byten, wr_ord});
            end
        end
        if (acc) tmr = 0;
        else if (n == 1) tmr = (tmr < int'(tmax)) ? tmr + 1 : int'(tmax);
        else tmr = 0;
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_ord = 0; ld_valid = 0;
        flush = 0; mdis = 0; drain_ready = 0;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [NB-1:0] be,
                          input logic [DW-1:0] d, input logic o);
        wr_valid = 1; wr_addr = a; wr_byten = be; wr_data = d; wr_ord = o;
    endtask

    initial begin
        int lat, nd, k;
        logic [DW-1:0] da, db;
        rst = 1; idle(); tmax = 0;
        wr_addr = 0; wr_data = 0; wr_byten = 0;
        ld_addr = 0; ld_byten = 0;
        step();
        rst = 0;
        step();
        chk("reset_empty", empty, 1);
        chk("reset_ready", wr_ready, 1);

        // Lone entry held for the full timer.
        tmax = 4;
        da = {$urandom, $urandom, $urandom, $urandom};
        set_wr(48'h100, 16'h000F, da, 0);
        step();
        wr_valid = 0; drain_ready = 1; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (seen_dv && lat < 0) begin
                lat = i;
                chk("t1_byten", seen_byten, 16'h000F);
            end
        end
        chk("t1_latency", lat, 5);

        // Two back-to-back stores to one line coalesce.
        tmax = 8;
        da = {$urandom, $urandom, $urandom, $urandom};
        db = {$urandom, $urandom, $urandom, $urandom};
        set_wr(48'h100, 16'h000F, da, 0);
        step();
        set_wr(48'h100, 16'h00F0, db, 0);
        step();
        wr_valid = 0;
        chk("t2_count", count, 1);
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (seen_dv) begin
                nd++;
                chk("t2_byten", seen_byten, 16'h00FF);
                chk("t2_data", seen_data,
                    (da & bmask(16'h000F)) | (db & bmask(16'h00F0)));
            end
        end
        chk("t2_ndrain", nd, 1);

        // Fill, stall on new line, merge when full, then FIFO drain.
        tmax = 0; drain_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(48'h1000 + 48'(i * 64), 16'h00FF,
                   {$urandom, $urandom, $urandom, $urandom}, 0);
            step();
        end
        wr_valid = 0; #1;
        chk("t3_full", full, 1);
        set_wr(48'h5000, 16'h0001, 0, 0); #1;
        chk("t3_ready_new", wr_ready, 0);
        step();
        set_wr(48'h1000 + 48'(7 * 64), 16'hF000, {4{32'hA5A5_5A5A}}, 0); #1;
        chk("t3_ready_merge", wr_ready, 1);
        step();
        wr_valid = 0; drain_ready = 1; k = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (seen_dv) begin
                chk("t3_order", seen_addr, 48'h1000 + 48'(k * 64));
                k++;
            end
        end
        chk("t3_ndrain", k, DEPTH);
        chk("t3_empty", empty, 1);

        // Per-byte youngest-writer forwarding.
        drain_ready = 0;
        da = {$urandom, $urandom, $urandom, $urandom};
        db = {$urandom, $urandom, $urandom, $urandom};
        set_wr(48'h200, 16'hFFFF, da, 0); step();
        set_wr(48'h300, 16'h0003, 0, 0); step();
        set_wr(48'h200, 16'h00FF, db, 0); step();
        wr_valid = 0;
        ld_valid = 1; ld_addr = 48'h204; ld_byten = 16'h0FFF; #1;
        chk("t4_fbyten", ld_fbyten, 16'h0FFF);
        chk("t4_fdata", ld_fdata,
            (db & bmask(16'h00FF)) | (da & bmask(16'h0F00)));
        chk("t4_conflict", ld_conf, 0);
        step();

        // Ordered store: load barrier, no hold, no merge.
        ld_valid = 0;
        set_wr(48'h700, 16'h0001, 1, 1); step();
        wr_valid = 0;
        ld_valid = 1; ld_addr = 48'h900; ld_byten = 16'h0001; #1;
        chk("t5_conflict", ld_conf, 1);
        step();
        ld_valid = 0; rst = 1; step(); rst = 0;
        tmax = 31;
        set_wr(48'h800, 16'h0001, 7, 1); step();
        wr_valid = 0; #1;
        chk("t5_drain_now", dv_o, 1);
        set_wr(48'h800, 16'h00F0, 9, 0); step();
        wr_valid = 0; #1;
        chk("t5_no_merge", count, 2);

        // Reset during an active drain handshake.
        rst = 1; step(); rst = 0; tmax = 0;
        for (int i = 0; i < 3; i++) begin
            set_wr(48'h400 + 48'(i * 16), 16'h0F0F, 48'(i), 0);
            step();
        end
        wr_valid = 0; drain_ready = 1; #1;
        chk("t6_handshake", dv_o, 1);
        rst = 1; step(); rst = 0;
        chk("t6_empty", empty, 1);
        chk("t6_count", count, 0);
        chk("t6_dv", dv_o, 0);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (seen_dv) nd++;
        end
        chk("t6_no_drain", nd, 0);

        // Randomized traffic over a few lines.
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) tmax = 5'($urandom_range(0, 7));
            rst = (c % 250 == 249);
            wr_valid = $urandom_range(0, 1);
            wr_addr = 48'h100 + 48'($urandom_range(0, 3) * 16) +
                      48'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_byten = 16'($urandom);
            wr_ord = ($urandom_range(0, 15) == 0);
            drain_ready = ($urandom_range(0, 2) != 0);
            ld_valid = $urandom_range(0, 1);
            ld_addr = 48'h100 + 48'($urandom_range(0, 3) * 16);
            ld_byten = 16'($urandom);
            mdis = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 0; idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
